// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU_* operation codes (RISC-V M-extension funct3 encoding)
//   - mdu_state_t: control FSM states
//   - helpers that classify which operands of an op are signed
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

    // MUL keeps both operands unsigned: the low half of the product is sign-agnostic.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one combinational radix-2 step on the 2*WIDTH accumulator.
//   i_is_div : 1 = restoring shift-subtract step, 0 = shift-add step
//   i_acc    : accumulator {hi, lo}
//                multiply: hi = partial product, lo = remaining multiplier bits
//                divide  : hi = partial remainder, lo = dividend bits / quotient bits
//   i_opnd   : multiplicand or divisor magnitude
//   o_acc    : accumulator after this step
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Trial operand is the remainder shifted left with the next dividend bit;
        // it needs WIDTH+1 bits, so bit WIDTH of the difference is the borrow.
        w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]} - {1'b0, i_opnd};
        if (i_is_div) begin
            if (!w_trial[WIDTH]) begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add becomes the new top bit after the right shift.
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit (RISC-V M extension), one iteration per cycle.
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   flush_i               : synchronous abort, returns to IDLE
//   valid_i / ready_o     : request handshake (ready_o only in IDLE)
//   mdu_op_i, A, B        : funct3 op code and operands, captured on accept
//   valid_o / ready_i     : result handshake
//   mdu_result_o          : registered result
//   neg_flag_o, zero_flag_o : sign bit / all-zero of the registered result
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       mdu_op_i,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] mdu_result_o,
    output logic             neg_flag_o,
    output logic             zero_flag_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [2:0]         r_op;
    logic               r_neg;
    logic               r_a_neg;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_ready;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_spec_result;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_result;

    // Operand conditioning and special-case detection on the live request.
    always_comb begin
        w_a_neg   = op_a_signed(mdu_op_i) & A[WIDTH-1];
        w_b_neg   = op_b_signed(mdu_op_i) & B[WIDTH-1];
        w_a_mag   = w_a_neg ? (~A + 1'b1) : A;
        w_b_mag   = w_b_neg ? (~B + 1'b1) : B;
        w_div0    = mdu_op_i[2] & (B == '0);
        w_ovf     = ((mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM)) &&
                    (A == MOST_NEG) && (B == '1);
        w_special = w_div0 | w_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU.
        if (w_div0) begin
            w_spec_result = mdu_op_i[1] ? A : '1;
        end else begin
            w_spec_result = mdu_op_i[1] ? '0 : A;
        end
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .i_is_div (r_op[2]),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_next)
    );

    // Sign correction and half selection after the last iteration.
    always_comb begin
        w_prod = r_neg   ? (~r_acc + 1'b1) : r_acc;
        w_quot = r_neg   ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem  = r_a_neg ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        case (r_op)
            MDU_MUL:                        w_fix_result = w_prod[WIDTH-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
            MDU_DIV, MDU_DIVU:              w_fix_result = w_quot;
            default:                        w_fix_result = w_rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_op     <= MDU_MUL;
            r_neg    <= 1'b0;
            r_a_neg  <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
        end else if (flush_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_op    <= mdu_op_i;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_a_neg <= w_a_neg;
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd  <= w_b_mag;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        if (w_special) begin
                            r_result <= w_spec_result;
                            r_valid  <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIXUP;
                    end
                end
                FIXUP: begin
                    r_result <= w_fix_result;
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o      = r_ready;
    assign valid_o      = r_valid;
    assign mdu_result_o = r_result;
    assign neg_flag_o   = r_result[WIDTH-1];
    assign zero_flag_o  = (r_result == '0);

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu (WIDTH=32).
// A 64-bit arithmetic reference model supplies expected results; a compare
// process checks every cycle valid_o is high, and each directed vector also
// carries a hand-computed literal result and latency.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  mdu_op_i;
    logic [31:0] A;
    logic [31:0] B;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] mdu_result_o;
    logic        neg_flag_o;
    logic        zero_flag_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_live = 1'b0;
    logic [31:0] exp_res = '0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .mdu_op_i     (mdu_op_i),
        .A            (A),
        .B            (B),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .mdu_result_o (mdu_result_o),
        .neg_flag_o   (neg_flag_o),
        .zero_flag_o  (zero_flag_o)
    );

    // Reference: RISC-V M-extension semantics via wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n_i === 1'b1 && valid_o === 1'b1) begin
            if (!exp_live) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_valid: valid_o=1 with no operation outstanding, result %h",
                         mdu_result_o);
            end else begin
                check("cmp_result", mdu_result_o, exp_res);
                check("cmp_neg", 32'(neg_flag_o), 32'(exp_res[31]));
                check("cmp_zero", 32'(zero_flag_o), 32'(exp_res == 32'd0));
                check("cmp_ready_busy", 32'(ready_o), 32'd0);
            end
        end
    end

    // Call at a negedge with the unit idle; returns #1 after the accept edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        check("ready_idle", 32'(ready_o), 32'd1);
        valid_i  = 1'b1;
        mdu_op_i = op;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        mdu_op_i = 3'($urandom);
        A        = $urandom;
        B        = $urandom;
    endtask

    // Full transaction; returns at a negedge with the unit back in IDLE.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int lat,
                          input int hold);
        int n = 0;
        check({name, "_model_pin"}, model(op, a, b), lit);
        exp_res  = model(op, a, b);
        exp_live = 1'b1;
        ready_i  = (hold == 0);
        start_op(op, a, b);
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (valid_o) break;
            check({name, "_busy_ready"}, 32'(ready_o), 32'd0);
        end
        if (!valid_o) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: valid_o never rose, required within %0d cycles", name, lat);
        end
        check({name, "_latency"}, 32'(n), 32'(lat));
        check({name, "_result"}, mdu_result_o, lit);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(valid_o), 32'd1);
            check({name, "_hold_result"}, mdu_result_o, lit);
        end
        ready_i = 1'b1;
        @(negedge clk);
        check({name, "_back_idle"}, {30'd0, ready_o, valid_o}, 32'b10);
        exp_live = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV] = '{
        '{"mul_neg",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
        '{"mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34},
        '{"mulhsu_m1",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
        '{"mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
        '{"mul_min_m1",  3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34},
        '{"div_neg",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34},
        '{"rem_neg",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34},
        '{"divu",        3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 34},
        '{"remu",        3'd7, 32'd10,         32'd3,         32'd1,         34},
        '{"div_zero",    3'd4, 32'd0,          32'd5,         32'd0,         34},
        '{"div_negb",    3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
        '{"rem_negb",    3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34},
        '{"sp_div0",     3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1},
        '{"sp_remu0",    3'd7, 32'd5,          32'd0,         32'd5,         1},
        '{"sp_div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{"sp_rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1}
    };

    initial begin
        rst_n_i  = 1'b0;
        flush_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        mdu_op_i = 3'd0;
        A        = '0;
        B        = '0;
        #12;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", mdu_result_o, 32'd0);
        check("rst_flags", {30'd0, neg_flag_o, zero_flag_o}, 32'b01);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat, 0);
        end

        // Backpressure, then an immediate follow-up op.
        run_op("bp_mulhu", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 34, 5);
        run_op("bp_next", 3'd5, 32'd100, 32'd7, 32'd14, 34, 0);

        // Flush mid-CALC: abort, no result may ever appear.
        start_op(3'd0, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_idle", {30'd0, ready_o, valid_o}, 32'b10);
        repeat (40) @(negedge clk);
        check("flush_no_valid", 32'(valid_o), 32'd0);

        // A request coincident with flush is ignored.
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        mdu_op_i = 3'd4;
        A        = 32'd5;
        B        = 32'd0;
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush_blocks_accept", {30'd0, ready_o, valid_o}, 32'b10);
        @(negedge clk);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 34, 0);

        // Asynchronous reset mid-CALC, checked between clock edges.
        start_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (10) @(negedge clk);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_result", mdu_result_o, 32'd0);
        check("arst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n_i = 1'b1;
        run_op("after_reset", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
